// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender (ZERO/SIGN/SHL/PFX) with a one-entry valid/ready output stage.
// Defining IMM_EXT_PFX_TMO_EN drops a held prefix after PFX_TMO idle cycles.
module imm_ext_pipe #(
    parameter int IN_W    = 6,
    parameter int OUT_W   = 16,
    parameter int PFX_W   = 10,
    parameter int SH      = 1,
    parameter int PFX_TMO = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    input  logic [PFX_W-1:0] pfx_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext,
    output logic             pfx_used,
    output logic             armed
);
    typedef enum logic {IDLE, ARMED} state_t;
    state_t           state, state_nxt;
    logic [PFX_W-1:0] prefix;
    logic [OUT_W-1:0] ext_nxt;
    logic             acc, is_pfx, take, expire;

    if (IN_W < 1 || OUT_W <= IN_W || IN_W + PFX_W != OUT_W || SH >= OUT_W || PFX_TMO < 1) begin : g_bad_params
        $error("imm_ext_pipe: inconsistent parameters");
    end

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;
    assign is_pfx   = mode == 2'b11;
    assign take     = acc && !flush && !is_pfx;

`ifdef IMM_EXT_PFX_TMO_EN
    localparam int CW = $clog2(PFX_TMO + 1);
    logic [CW-1:0] cnt;
    // Idle cycles spent in ARMED; any accept restarts the count.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (state != ARMED || acc) ? '0 : cnt + 1'b1;
    assign expire = state == ARMED && !acc && cnt == CW'(PFX_TMO - 1);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            prefix    <= '0;
            out_valid <= 1'b0;
            ext       <= '0;
            pfx_used  <= 1'b0;
        end else begin
            state     <= state_nxt;
            prefix    <= (acc && is_pfx && !flush) ? pfx_in : expire ? '0 : prefix;
            out_valid <= !flush && (take || (out_valid && !out_ready));
            if (take) begin
                ext      <= ext_nxt;
                pfx_used <= state == ARMED;
            end
        end

    always_comb
        state_nxt = flush ? IDLE : acc ? (is_pfx ? ARMED : IDLE) : expire ? IDLE : state;

    // A held prefix replaces the mode extension entirely.
    always_comb begin
        armed   = state == ARMED;
        ext_nxt = armed          ? {prefix, imm} :
                  mode == 2'b00  ? {{PFX_W{1'b0}}, imm} :
                  mode == 2'b01  ? {{PFX_W{imm[IN_W-1]}}, imm} :
                                   {{PFX_W{1'b0}}, imm} << SH;
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: vector table, directed corner sequences and randomized run against a reference model.
module tb_imm_ext_pipe;
    localparam int IN_W = 6, OUT_W = 16, SH = 1, PFX_TMO = 4;
    localparam logic [1:0] M_ZERO = 2'd0, M_SIGN = 2'd1, M_SHL = 2'd2, M_PFX = 2'd3;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, pfx_used, armed;
    logic [5:0]  imm = '0;
    logic [1:0]  mode = '0;
    logic [9:0]  pfx_in = '0;
    logic [15:0] ext;

    int n_chk = 0, n_fail = 0;

    imm_ext_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .mode(mode), .pfx_in(pfx_in), .out_valid(out_valid), .out_ready(out_ready),
        .ext(ext), .pfx_used(pfx_used), .armed(armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [5:0]  imm;
        logic [9:0]  pfx;
        logic        v;
        logic [15:0] ext;
        logic        used;
        logic        arm;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic go(input logic v, input logic [1:0] m, input logic [5:0] i,
                      input logic [9:0] p, input logic r, input logic f);
        in_valid = v; mode = m; imm = i; pfx_in = p; out_ready = r; flush = f;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_ext(input int m, input int i, input bit arm, input int p);
        if (arm) return 16'(p * (1 << IN_W) + i);
        if (m == 0) return 16'(i);
        if (m == 1) return 16'(i >= (1 << (IN_W - 1)) ? i - (1 << IN_W) + (1 << OUT_W) : i);
        return 16'(i * (1 << SH));
    endfunction

    bit          m_valid, m_armed, m_used, acc;
    int          m_pfx, m_cnt;
    logic [15:0] m_ext;

    initial begin
        tbl[0] = '{M_ZERO, 6'h25, 10'h000, 1'b1, 16'h0025, 1'b0, 1'b0};
        tbl[1] = '{M_SIGN, 6'h25, 10'h000, 1'b1, 16'hFFE5, 1'b0, 1'b0};
        tbl[2] = '{M_SHL,  6'h25, 10'h000, 1'b1, 16'h004A, 1'b0, 1'b0};
        tbl[3] = '{M_PFX,  6'h00, 10'h2AB, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{M_SIGN, 6'h3F, 10'h000, 1'b1, 16'hAAFF, 1'b1, 1'b0};
        tbl[5] = '{M_SIGN, 6'h20, 10'h000, 1'b1, 16'hFFE0, 1'b0, 1'b0};
        tbl[6] = '{M_SHL,  6'h3F, 10'h000, 1'b1, 16'h007E, 1'b0, 1'b0};
        tbl[7] = '{M_ZERO, 6'h00, 10'h000, 1'b1, 16'h0000, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chkb("rst_out_valid", out_valid, 1'b0);
        chk ("rst_ext", ext, 16'h0000);
        chkb("rst_pfx_used", pfx_used, 1'b0);
        chkb("rst_armed", armed, 1'b0);
        chkb("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            go(1'b1, tbl[k].mode, tbl[k].imm, tbl[k].pfx, 1'b1, 1'b0);
            chkb($sformatf("tbl%0d_valid", k), out_valid, tbl[k].v);
            chkb($sformatf("tbl%0d_armed", k), armed, tbl[k].arm);
            if (tbl[k].v) begin
                chk ($sformatf("tbl%0d_ext", k), ext, tbl[k].ext);
                chkb($sformatf("tbl%0d_used", k), pfx_used, tbl[k].used);
            end
        end
        go(1'b0, M_ZERO, 6'h00, 10'h0, 1'b1, 1'b0);

        // backpressure: first result held while the next one waits
        go(1'b1, M_SIGN, 6'h21, 10'h0, 1'b0, 1'b0);
        chk ("bp_first", ext, 16'hFFE1);
        chkb("bp_ready0", in_ready, 1'b0);
        for (int k = 0; k < 2; k++) begin
            go(1'b1, M_SIGN, 6'h05, 10'h0, 1'b0, 1'b0);
            chkb($sformatf("bp_stall%0d_valid", k), out_valid, 1'b1);
            chk ($sformatf("bp_stall%0d_ext", k), ext, 16'hFFE1);
            chkb($sformatf("bp_stall%0d_ready", k), in_ready, 1'b0);
        end
        go(1'b1, M_SIGN, 6'h05, 10'h0, 1'b1, 1'b0);
        chk ("bp_second", ext, 16'h0005);
        chkb("bp_second_valid", out_valid, 1'b1);
        go(1'b1, M_SIGN, 6'h3A, 10'h0, 1'b1, 1'b0);
        chk ("bp_third", ext, 16'hFFFA);
        chkb("bp_third_valid", out_valid, 1'b1);
        go(1'b0, M_SIGN, 6'h00, 10'h0, 1'b1, 1'b0);
        chkb("bp_drained", out_valid, 1'b0);

        // flush discards a same-cycle accept and the held prefix
        go(1'b1, M_PFX, 6'h00, 10'h155, 1'b1, 1'b0);
        chkb("fl_armed", armed, 1'b1);
        in_valid = 1'b1; mode = M_ZERO; imm = 6'h01; flush = 1'b1;
        #1;
        chkb("fl_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        chkb("fl_valid", out_valid, 1'b0);
        chkb("fl_armed_clr", armed, 1'b0);
        go(1'b1, M_ZERO, 6'h01, 10'h0, 1'b1, 1'b0);
        chk ("fl_next_ext", ext, 16'h0001);
        chkb("fl_next_used", pfx_used, 1'b0);
        go(1'b1, M_ZERO, 6'h02, 10'h0, 1'b0, 1'b0);
        go(1'b0, M_ZERO, 6'h00, 10'h0, 1'b0, 1'b1);
        chkb("fl_pending_drop", out_valid, 1'b0);

        // asynchronous reset between clock edges
        go(1'b1, M_PFX, 6'h00, 10'h2AB, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chkb("ar_armed", armed, 1'b0);
        #2 rst_n = 1'b1;
        go(1'b1, M_SIGN, 6'h25, 10'h0, 1'b0, 1'b0);
        chkb("ar_pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chkb("ar_valid", out_valid, 1'b0);
        chk ("ar_ext", ext, 16'h0000);
        chkb("ar_used", pfx_used, 1'b0);
        #2 rst_n = 1'b1;
        go(1'b0, M_ZERO, 6'h00, 10'h0, 1'b1, 1'b0);

`ifdef IMM_EXT_PFX_TMO_EN
        go(1'b1, M_PFX, 6'h00, 10'h1C3, 1'b1, 1'b0);
        for (int k = 1; k <= PFX_TMO; k++) begin
            go(1'b0, M_ZERO, 6'h00, 10'h0, 1'b1, 1'b0);
            chkb($sformatf("tmo_idle%0d_armed", k), armed, k < PFX_TMO);
        end
        go(1'b1, M_ZERO, 6'h05, 10'h0, 1'b1, 1'b0);
        chk ("tmo_ext", ext, 16'h0005);
        chkb("tmo_used", pfx_used, 1'b0);
        go(1'b1, M_PFX, 6'h00, 10'h3FF, 1'b1, 1'b0);
        for (int k = 1; k < PFX_TMO; k++) go(1'b0, M_ZERO, 6'h00, 10'h0, 1'b1, 1'b0);
        go(1'b1, M_ZERO, 6'h05, 10'h0, 1'b1, 1'b0);
        chk ("tmo_race_ext", ext, 16'hFFC5);
        chkb("tmo_race_used", pfx_used, 1'b1);
`endif

        // randomized run against the reference model
        go(1'b0, M_ZERO, 6'h00, 10'h0, 1'b1, 1'b1);
        m_valid = 0; m_armed = 0; m_used = 0; m_pfx = 0; m_cnt = 0; m_ext = '0;
        for (int k = 0; k < 400; k++) begin
            in_valid  = $urandom_range(0, 9) < 7;
            mode      = 2'($urandom);
            imm       = 6'($urandom);
            pfx_in    = 10'($urandom);
            out_ready = $urandom_range(0, 9) < 6;
            flush     = $urandom_range(0, 19) == 0;
            #1;
            chkb("rnd_in_ready", in_ready, !m_valid || out_ready);
            acc = in_valid && (!m_valid || out_ready);
            if (flush) begin
                m_valid = 0; m_armed = 0; m_cnt = 0;
            end else if (acc && mode == M_PFX) begin
                m_valid = 0; m_armed = 1; m_pfx = int'(pfx_in); m_cnt = 0;
            end else if (acc) begin
                m_ext = ref_ext(int'(mode), int'(imm), m_armed, m_pfx);
                m_used = m_armed; m_armed = 0; m_valid = 1; m_cnt = 0;
            end else begin
                if (out_ready) m_valid = 0;
`ifdef IMM_EXT_PFX_TMO_EN
                if (m_armed) begin
                    m_cnt++;
                    if (m_cnt == PFX_TMO) m_armed = 0;
                end
`endif
            end
            @(posedge clk);
            #1;
            chkb("rnd_valid", out_valid, m_valid);
            chkb("rnd_armed", armed, m_armed);
            if (m_valid) begin
                chk ("rnd_ext", ext, m_ext);
                chkb("rnd_used", pfx_used, m_used);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, parametrised immediate extender for the decode stage; successor to the 6-to-16-bit combinational extender.
- Adds generic widths, four extension modes, a prefix register for full-width constants, and a valid/ready output stage with flush.
- Sits between the instruction decoder and the ID/EX pipeline register.

Parameters:
- IN_W, 6: immediate input width; must be at least 1.
- OUT_W, 16: extended output width; must be greater than IN_W.
- PFX_W, 10: prefix width; must satisfy IN_W+PFX_W = OUT_W.
- SH, 1: left-shift amount for SHL mode; must be less than OUT_W.
- PFX_TMO, 4: prefix timeout in cycles; used only with IMM_EXT_PFX_TMO_EN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  imm/mode/pfx_in valid
- in_ready  out  1  block can accept this cycle
- imm  in  IN_W  raw immediate field
- mode  in  2  00 ZERO, 01 SIGN, 10 SHL, 11 PFX
- pfx_in  in  PFX_W  prefix bits, sampled in PFX mode only
- out_valid  out  1  ext valid
- out_ready  in  1  consumer accepts ext
- ext  out  OUT_W  extended immediate
- pfx_used  out  1  ext was built from a prefix
- armed  out  1  prefix held

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, ext=0, pfx_used=0, armed=0, prefix register=0, state IDLE.
- Accept: in_valid & in_ready. in_ready = !out_valid | out_ready (one-entry output register; full throughput with no bubble).
- Latency: 1 cycle from accept to out_valid=1. ext and pfx_used are held stable while out_valid & !out_ready.
- out_valid next: set on an accepted non-PFX transaction; else cleared on out_ready; else held.
- FSM IDLE, accepted transaction:
  - ZERO: ext={0, imm}.
  - SIGN: ext={{PFX_W{imm[IN_W-1]}}, imm}.
  - SHL: ext=({0, imm} << SH), truncated to OUT_W.
  - For ZERO/SIGN/SHL, pfx_used=0.
  - PFX: prefix<=pfx_in, go to ARMED, no output produced (out_valid not set by this transaction).
- FSM ARMED (armed=1):
  - Accepted ZERO/SIGN/SHL: ext={prefix, imm}; the mode extension is ignored; pfx_used=1; go to IDLE.
  - Accepted PFX: prefix overwritten with pfx_in; stay ARMED.
- Flush, same cycle as anything else (flush wins):
  - out_valid<=0, state<=IDLE, armed<=0.
  - Any transaction accepted that cycle is discarded.
  - in_ready is unaffected by flush.
- Stall: while out_valid & !out_ready, in_ready=0. Prefix state and mode inputs are ignored.
- Reset asserted mid-stall: everything returns to reset values immediately; no partial output survives.
- mode and imm are don't-care when in_valid=0.

Optional Feature:
- Macro: IMM_EXT_PFX_TMO_EN.
- Defined:
  - A counter loads 0 on entering ARMED or on a PFX overwrite.
  - The counter increments each cycle in ARMED without an accepted transaction.
  - When it reaches PFX_TMO, the block returns to IDLE and the prefix is dropped.
  - The next immediate is extended normally with pfx_used=0.
  - If an accept and the expiry happen in the same cycle, the accept wins and the prefix is used.
- Undefined: no counter; the prefix is held indefinitely until consumed, flushed or reset.

Test Plan:
- Reset then modes, defaults:
  - imm=6'b100101, ZERO -> ext=16'h0025, one cycle later.
  - Same imm, SIGN -> ext=16'hFFE5.
  - SHL -> ext=16'h004A.
  - pfx_used=0 for all three.
- Prefix:
  - PFX with pfx_in=10'h2AB -> no out_valid, armed=1.
  - Then SIGN imm=6'h3F -> ext=16'hAAFF, pfx_used=1, armed=0.
- Back-to-back with backpressure:
  - Drive 3 SIGN transactions with out_ready=0 for 2 cycles.
  - First ext held stable and in_ready=0 during the stall.
  - All three outputs then appear in order with no loss or duplication.
- Flush:
  - After PFX, assert flush together with an accepted ZERO imm=6'h01 -> out_valid=0 and armed=0 next cycle.
  - Following ZERO imm=6'h01 -> ext=16'h0001.
- Async reset:
  - Pulse rst_n low mid-cycle while out_valid=1 and armed=1 -> outputs clear immediately, before the next clock edge.
- With IMM_EXT_PFX_TMO_EN, PFX_TMO=4:
  - PFX then 4 idle cycles -> armed=0.
  - ZERO imm=6'h05 -> ext=16'h0005, pfx_used=0.
  - Repeat with the accept on cycle 4 -> pfx_used=1.
